// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART MMIO bridge: register offsets, status bit
// positions, TX handshake states and the busy-wait timeout.
package uart_ctrl_pkg;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int unsigned ST_TX_RDY   = 0;
    localparam int unsigned ST_RX_AVAIL = 1;
    localparam int unsigned ST_RX_OVR   = 2;

    localparam int unsigned TX_BUSY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head. A pop on empty is
// ignored; a push while full succeeds only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// CPU bus bridge to the async_receiver/async_transmitter pair with RX/TX FIFOs.
// Define UART_MMIO_IRQ_EN to generate the registered RX interrupt.
module uart_mmio_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_ce,
    input  logic        bus_we,
    input  logic        bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        rx_clear,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        irq
);

    logic            rd_data_stb;
    logic            rd_status_stb;
    logic            wr_data_stb;

    logic            rx_push;
    logic            rx_full;
    logic            rx_empty;
    logic [7:0]      rx_head;
    logic [ADDR_W:0] rx_count;
    logic            rx_overrun;
    logic            overrun_set;

    logic            tx_push;
    logic            tx_pop;
    logic            tx_full;
    logic            tx_empty;
    logic [7:0]      tx_head;
    logic [ADDR_W:0] tx_count;

    tx_state_t       tx_state;
    logic [2:0]      busy_cnt;
    logic [31:0]     status_word;

    assign rd_data_stb   = bus_ce & ~bus_we & (bus_addr == ADDR_DATA);
    assign rd_status_stb = bus_ce & ~bus_we & (bus_addr == ADDR_STATUS);
    assign wr_data_stb   = bus_ce &  bus_we & (bus_addr == ADDR_DATA);

    assign rx_clear = rx_ready;

    // A full FIFO still accepts a byte when the CPU drains one in the same cycle.
    assign rx_push     = rx_ready & (~rx_full | rd_data_stb);
    assign overrun_set = rx_ready & rx_full & ~rd_data_stb;

    assign tx_pop  = (tx_state == TX_IDLE) & ~tx_empty & ~tx_busy;
    assign tx_push = wr_data_stb & (~tx_full | tx_pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .AW    (ADDR_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rd_data_stb),
        .wdata (rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .AW    (ADDR_W)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (bus_wdata),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    always_comb begin
        status_word              = '0;
        status_word[ST_TX_RDY]   = (tx_count != (ADDR_W+1)'(FIFO_DEPTH));
        status_word[ST_RX_AVAIL] = (rx_count != '0);
        status_word[ST_RX_OVR]   = rx_overrun;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rdata  <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (rd_data_stb) begin
                bus_rdata <= rx_empty ? '0 : {24'b0, rx_head};
            end else if (rd_status_stb) begin
                bus_rdata <= status_word;
            end
            // A fresh overrun in the clearing cycle must not be lost.
            if (overrun_set) begin
                rx_overrun <= 1'b1;
            end else if (rd_status_stb) begin
                rx_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy_cnt <= '0;
        end else begin
            tx_start <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_data  <= tx_head;
                        tx_start <= 1'b1;
                        busy_cnt <= '0;
                        tx_state <= TX_WAIT_BUSY;
                    end
                end
                TX_WAIT_BUSY: begin
                    if (tx_busy) begin
                        tx_state <= TX_WAIT_DONE;
                    end else if (busy_cnt == 3'(TX_BUSY_TIMEOUT - 1)) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                TX_WAIT_DONE: begin
                    if (!tx_busy) begin
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

`ifdef UART_MMIO_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (rx_count != '0) | rx_overrun;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: register access, RX overrun, TX handshake
// against a transmitter model, TX full, and reset during transmission.
module tb_uart_mmio_ctrl;
    import uart_ctrl_pkg::*;

`ifdef UART_MMIO_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_ce = 1'b0;
    logic        bus_we = 1'b0;
    logic        bus_addr = 1'b0;
    logic [7:0]  bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic [7:0]  rx_data = '0;
    logic        rx_ready = 1'b0;
    logic        rx_clear;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        irq;

    int checks = 0;
    int failures = 0;

    logic        model_busy = 1'b0;
    logic        force_busy = 1'b0;
    int          busy_len = 20;
    int          busy_left = 0;
    int          nstarts = 0;
    int          start_while_busy = 0;
    int          cyc = 0;
    logic [7:0]  start_log [32];
    int          start_cyc [32];

    assign tx_busy = model_busy | force_busy;

    always #5 clk = ~clk;

    uart_mmio_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus_ce    (bus_ce),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rx_clear  (rx_clear),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .irq       (irq)
    );

    // Transmitter model: raises busy on start and holds it busy_len cycles.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (tx_start === 1'b1) begin
            if (tx_busy) start_while_busy = start_while_busy + 1;
            if (nstarts < 32) begin
                start_log[nstarts] = tx_data;
                start_cyc[nstarts] = cyc;
            end
            nstarts = nstarts + 1;
            model_busy <= (busy_len > 0);
            busy_left = busy_len;
        end else if (model_busy) begin
            if (busy_left <= 1) model_busy <= 1'b0;
            else busy_left = busy_left - 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_read(input logic a, output logic [31:0] d);
        @(negedge clk);
        bus_ce = 1'b1; bus_we = 1'b0; bus_addr = a;
        @(negedge clk);
        bus_ce = 1'b0;
        d = bus_rdata;
    endtask

    task automatic bus_write(input logic a, input logic [7:0] v);
        @(negedge clk);
        bus_ce = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = v;
        @(negedge clk);
        bus_ce = 1'b0; bus_we = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] v);
        @(negedge clk);
        rx_data = v; rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget, input string name);
        for (int i = 0; i < budget && nstarts < n; i++) @(negedge clk);
        checks++;
        if (nstarts < n) begin
            failures++;
            $display("FAIL %s_timeout got=%0d starts exp=%0d", name, nstarts, n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        tick(3);
        checks++; if (bus_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", bus_rdata, 32'h0); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        rst = 1'b0;
        bus_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL reset_status got=%h exp=%h", d, 32'h1); end
        bus_read(ADDR_DATA, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_data_empty got=%h exp=%h", d, 32'h0); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq_after got=%b exp=0", irq); end
    endtask

    task automatic test_rx();
        logic [31:0] d;
        @(negedge clk);
        rx_data = 8'h41; rx_ready = 1'b1;
        #1;
        checks++; if (rx_clear !== 1'b1) begin failures++; $display("FAIL rx_clear_high got=%b exp=1", rx_clear); end
        @(negedge clk);
        rx_ready = 1'b0;
        #1;
        checks++; if (rx_clear !== 1'b0) begin failures++; $display("FAIL rx_clear_low got=%b exp=0", rx_clear); end
        push_rx(8'h42);
        tick(2);
        checks++; if (irq !== IRQ_ON) begin failures++; $display("FAIL rx_irq_set got=%b exp=%b", irq, IRQ_ON); end
        bus_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h3) begin failures++; $display("FAIL rx_status_avail got=%h exp=%h", d, 32'h3); end
        bus_read(ADDR_DATA, d);
        checks++; if (d !== 32'h41) begin failures++; $display("FAIL rx_data0 got=%h exp=%h", d, 32'h41); end
        bus_read(ADDR_DATA, d);
        checks++; if (d !== 32'h42) begin failures++; $display("FAIL rx_data1 got=%h exp=%h", d, 32'h42); end
        bus_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL rx_status_empty got=%h exp=%h", d, 32'h1); end
        tick(2);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rx_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        for (int i = 0; i < 16; i++) push_rx(8'(8'h10 + i));
        push_rx(8'h99);
        bus_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h7) begin failures++; $display("FAIL ovr_status_set got=%h exp=%h", d, 32'h7); end
        bus_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h3) begin failures++; $display("FAIL ovr_status_cleared got=%h exp=%h", d, 32'h3); end
        for (int i = 0; i < 16; i++) begin
            bus_read(ADDR_DATA, d);
            checks++;
            if (d !== 32'(8'h10 + i)) begin
                failures++; $display("FAIL ovr_drain[%0d] got=%h exp=%h", i, d, 32'(8'h10 + i));
            end
        end
        bus_read(ADDR_DATA, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL ovr_dropped_absent got=%h exp=%h", d, 32'h0); end
        bus_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL ovr_status_final got=%h exp=%h", d, 32'h1); end
    endtask

    task automatic test_tx();
        busy_len = 20; nstarts = 0; start_while_busy = 0;
        bus_write(ADDR_DATA, 8'h55);
        bus_write(ADDR_DATA, 8'hAA);
        wait_starts(2, 200, "tx");
        tick(40);
        checks++; if (nstarts !== 2) begin failures++; $display("FAIL tx_start_count got=%0d exp=2", nstarts); end
        checks++; if (start_log[0] !== 8'h55) begin failures++; $display("FAIL tx_byte0 got=%h exp=55", start_log[0]); end
        checks++; if (start_log[1] !== 8'hAA) begin failures++; $display("FAIL tx_byte1 got=%h exp=aa", start_log[1]); end
        checks++; if (start_while_busy !== 0) begin failures++; $display("FAIL tx_start_during_busy got=%0d exp=0", start_while_busy); end
        checks++; if (start_cyc[1] - start_cyc[0] <= 20) begin failures++; $display("FAIL tx_gap got=%0d exp=>20", start_cyc[1] - start_cyc[0]); end
    endtask

    task automatic test_timeout();
        busy_len = 0; nstarts = 0;
        bus_write(ADDR_DATA, 8'h5A);
        bus_write(ADDR_DATA, 8'hA5);
        wait_starts(2, 100, "timeout");
        tick(10);
        checks++; if (nstarts !== 2) begin failures++; $display("FAIL timeout_count got=%0d exp=2", nstarts); end
        checks++; if (start_log[1] !== 8'hA5) begin failures++; $display("FAIL timeout_byte1 got=%h exp=a5", start_log[1]); end
        checks++;
        if (start_cyc[1] - start_cyc[0] < 4 || start_cyc[1] - start_cyc[0] > 6) begin
            failures++; $display("FAIL timeout_gap got=%0d exp=4..6", start_cyc[1] - start_cyc[0]);
        end
    endtask

    task automatic test_tx_full();
        logic [31:0] d;
        busy_len = 5;
        tick(5);
        force_busy = 1'b1; nstarts = 0; start_while_busy = 0;
        for (int i = 0; i < 16; i++) bus_write(ADDR_DATA, 8'(8'h60 + i));
        bus_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL full_status got=%h exp=%h", d, 32'h0); end
        bus_write(ADDR_DATA, 8'hEE);
        bus_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL full_status_after_drop got=%h exp=%h", d, 32'h0); end
        checks++; if (nstarts !== 0) begin failures++; $display("FAIL full_no_start_while_held got=%0d exp=0", nstarts); end
        force_busy = 1'b0;
        wait_starts(16, 1000, "full");
        tick(50);
        checks++; if (nstarts !== 16) begin failures++; $display("FAIL full_start_count got=%0d exp=16", nstarts); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (start_log[i] !== 8'(8'h60 + i)) begin
                failures++; $display("FAIL full_byte[%0d] got=%h exp=%h", i, start_log[i], 8'(8'h60 + i));
            end
        end
        bus_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL full_status_final got=%h exp=%h", d, 32'h1); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        busy_len = 30; nstarts = 0; start_while_busy = 0;
        bus_write(ADDR_DATA, 8'h71);
        bus_write(ADDR_DATA, 8'h72);
        bus_write(ADDR_DATA, 8'h73);
        wait_starts(1, 50, "mid_first");
        tick(2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        bus_read(ADDR_STATUS, d);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL mid_status got=%h exp=%h", d, 32'h1); end
        bus_write(ADDR_DATA, 8'h33);
        tick(5);
        checks++; if (nstarts !== 1) begin failures++; $display("FAIL mid_no_start_while_busy got=%0d exp=1", nstarts); end
        wait_starts(2, 100, "mid_new");
        tick(40);
        checks++; if (nstarts !== 2) begin failures++; $display("FAIL mid_start_count got=%0d exp=2", nstarts); end
        checks++; if (start_log[0] !== 8'h71) begin failures++; $display("FAIL mid_byte0 got=%h exp=71", start_log[0]); end
        checks++; if (start_log[1] !== 8'h33) begin failures++; $display("FAIL mid_byte1 got=%h exp=33", start_log[1]); end
        checks++; if (start_while_busy !== 0) begin failures++; $display("FAIL mid_start_during_busy got=%0d exp=0", start_while_busy); end
    endtask

    initial begin
        test_reset();
        test_rx();
        test_overrun();
        test_tx();
        test_timeout();
        test_tx_full();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
